oam_dma: RTL and testbench

- Sprite-OAM DMA controller and system-bus arbiter between the 6502 core (`cpu`) and memory.
- A CPU write to the DMA register starts a copy of one 256-byte page (`{V, 8'h00}`..`{V, 8'hFF}`) into the PPU OAM data port.
- During the copy the block halts the CPU through `ready` and owns the address/data bus, interleaving one memory read and one OAM write per byte.
- When idle it passes CPU bus signals straight through to memory.

---
 rtl/nes_pkg.sv | 22 ++
 rtl/oam_dma_bus_mux.sv | 14 +
 rtl/oam_dma.sv | 132 +++++++++++++
 tb/tb_oam_dma.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES system-bus definitions: OAM DMA state encoding, register addresses
// and the bus bundle used by the CPU/DMA arbiter.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [7:0]  data;
  } bus_t;

endpackage

// File: rtl/oam_dma_bus_mux.sv
// System-bus arbiter: selects either the CPU or the DMA engine as the
// driver of address, write strobe and write data.
module bus_mux
  import nes_pkg::*;
(
  input  logic dma_own,
  input  bus_t cpu_bus,
  input  bus_t dma_bus,
  output bus_t bus
);

  assign bus = dma_own ? dma_bus : cpu_bus;

endmodule

// File: rtl/oam_dma.sv
// Sprite-OAM DMA controller: halts the 6502, copies one 256-byte page into the
// PPU OAM data port (one read + one write per byte) and otherwise passes the CPU through.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  output logic        cpu_ready,
  input  logic [7:0]  mem_d_in,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_d_out,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_buf;
  logic       parity;

  logic       trigger;
  logic       dma_own;
  bus_t       cpu_bus;
  bus_t       dma_bus;
  bus_t       mux_bus;

  assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

  // Even/odd cycle marker; memory reads are only allowed on even cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity <= 1'b0;
    else        parity <= ~parity;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      data_buf   <= 8'h00;
      cpu_ready  <= 1'b1;
      dma_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state      <= HALT;
            page       <= cpu_d_out;
            idx        <= 8'h00;
            cpu_ready  <= 1'b0;
            dma_active <= 1'b1;
          end
        end
        // The 6502 cannot stall on a write, so wait for its first read cycle.
        HALT: begin
          if (!cpu_write) state <= ALIGN;
        end
        // Leaving now puts READ on the next cycle, whose parity is ~parity.
        ALIGN: begin
          if (parity) state <= READ;
        end
        READ: begin
          data_buf <= mem_d_in;
          state    <= WRITE;
        end
        WRITE: begin
          idx <= idx + 8'd1;
          if (idx == LAST_IDX) begin
            state      <= IDLE;
            cpu_ready  <= 1'b1;
            dma_active <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        default: begin
          state      <= IDLE;
          cpu_ready  <= 1'b1;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

  // HALT still passes the CPU through; the DMA owns the bus from ALIGN onward.
  assign dma_own = (state == ALIGN) || (state == READ) || (state == WRITE);

  assign cpu_bus.addr  = cpu_addr;
  assign cpu_bus.write = cpu_write;
  assign cpu_bus.data  = cpu_d_out;

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dma_bus.addr  = cpu_addr;
    dma_bus.write = 1'b0;
    dma_bus.data  = data_buf;
    case (state)
      READ: begin
        dma_bus.addr = {page, idx};
      end
      WRITE: begin
        dma_bus.addr  = OAM_DATA_ADDR;
        dma_bus.write = 1'b1;
      end
      default: ;
    endcase
  end

  bus_mux u_bus_mux (
    .dma_own (dma_own),
    .cpu_bus (cpu_bus),
    .dma_bus (dma_bus),
    .bus     (mux_bus)
  );

  assign bus_addr  = mux_bus.addr;
  assign bus_write = mux_bus.write;
  assign bus_d_out = mux_bus.data;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory model returns a fixed pattern per address,
// a negedge monitor tallies OAM writes, and one initial block runs the scenarios.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'hC000;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_d_out = 8'h00;
  logic        cpu_ready;
  logic [7:0]  mem_d_in;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic [7:0]  bus_d_out;
  logic        dma_active;

  int total = 0;
  int bad = 0;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_d_out  (cpu_d_out),
    .cpu_ready  (cpu_ready),
    .mem_d_in   (mem_d_in),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_d_out  (bus_d_out),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Page 0x02 holds i^5A; other pages get a page-dependent twist.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  assign mem_d_in = mem_val(bus_addr);

  // Reference cycle parity: 0 on the first cycle after reset, then alternating.
  logic tb_par;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;
  end

  int          oam_cnt, ready_low, src_bad, data_bad, par_bad;
  logic [7:0]  exp_page, first_data, last_data;
  logic [15:0] first_rd, last_rd, prev_addr;
  logic        prev_par;

  // The source read is the bus cycle right before each write to 0x2004.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_write === 1'b1 && bus_addr === 16'h2004) begin
        if (prev_addr !== {exp_page, oam_cnt[7:0]}) src_bad++;
        if (bus_d_out !== mem_val(prev_addr)) data_bad++;
        if (prev_par !== 1'b0) par_bad++;
        if (oam_cnt == 0) begin
          first_data = bus_d_out;
          first_rd   = prev_addr;
        end
        last_data = bus_d_out;
        last_rd   = prev_addr;
        oam_cnt++;
      end
      if (cpu_ready === 1'b0) ready_low++;
      prev_addr = bus_addr;
      prev_par  = tb_par;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input logic [7:0] pg);
    oam_cnt = 0; ready_low = 0; src_bad = 0; data_bad = 0; par_bad = 0;
    exp_page = pg; first_data = 8'h00; last_data = 8'h00;
    first_rd = 16'h0000; last_rd = 16'h0000;
  endtask

  // Positions the bench so the current cycle has parity p, then drives the trigger.
  task automatic trigger(input logic [7:0] pg, input logic p);
    cycle();
    if (tb_par !== p) cycle();
    cpu_addr  = 16'h4014;
    cpu_write = 1'b1;
    cpu_d_out = pg;
  endtask

  task automatic cpu_read();
    cpu_addr  = 16'hC000;
    cpu_write = 1'b0;
    cpu_d_out = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (cpu_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    // Reset state and passthrough.
    cpu_addr = 16'h1234; cpu_write = 1'b1; cpu_d_out = 8'hAB;
    #2 reset = 1'b0;
    #1;
    check("rst_ready",  32'(cpu_ready), 1);
    check("rst_active", 32'(dma_active), 0);
    check("rst_addr",   32'(bus_addr), 'h1234);
    check("rst_write",  32'(bus_write), 1);
    check("rst_data",   32'(bus_d_out), 'hAB);
    cycle(); cycle();
    cpu_read();
    reset = 1'b1;
    cycle(); cycle();

    // Basic transfer, trigger cycle with parity 1: 1 HALT + 1 ALIGN + 512.
    clear_stats(8'h02);
    trigger(8'h02, 1'b1);
    #1;
    check("trig_pass_addr",  32'(bus_addr), 'h4014);
    check("trig_pass_write", 32'(bus_write), 1);
    check("trig_pass_data",  32'(bus_d_out), 'h02);
    cycle();
    cpu_read();
    check("basic_ready_low_now", 32'(cpu_ready), 0);
    check("basic_active_now",    32'(dma_active), 1);
    wait_done("basic");
    check("basic_cnt",        32'(oam_cnt), 256);
    check("basic_src",        32'(src_bad), 0);
    check("basic_data",       32'(data_bad), 0);
    check("basic_first_data", 32'(first_data), 'h5A);
    check("basic_last_data",  32'(last_data), 'hA5);
    check("basic_ready_low",  32'(ready_low), 514);
    check("basic_parity",     32'(par_bad), 0);
    check("basic_idle",       32'(dma_active), 0);
    cycle(); cycle();

    // Odd alignment: trigger on parity 0 costs a second ALIGN cycle.
    clear_stats(8'h02);
    trigger(8'h02, 1'b0);
    cycle();
    cpu_read();
    wait_done("odd");
    check("odd_cnt",       32'(oam_cnt), 256);
    check("odd_data",      32'(data_bad), 0);
    check("odd_ready_low", 32'(ready_low), 515);
    check("odd_parity",    32'(par_bad), 0);
    cycle(); cycle();

    // Write-extended halt: trigger plus two more CPU writes, then a read.
    clear_stats(8'h02);
    trigger(8'h02, 1'b1);
    cycle();
    cpu_addr = 16'h0300; cpu_write = 1'b1; cpu_d_out = 8'h11;
    #1;
    check("wext_addr0",  32'(bus_addr), 'h0300);
    check("wext_write0", 32'(bus_write), 1);
    check("wext_data0",  32'(bus_d_out), 'h11);
    check("wext_halted", 32'(cpu_ready), 0);
    cycle();
    cpu_addr = 16'h0301; cpu_d_out = 8'h22;
    #1;
    check("wext_addr1",  32'(bus_addr), 'h0301);
    check("wext_data1",  32'(bus_d_out), 'h22);
    cycle();
    cpu_read();
    wait_done("wext");
    check("wext_cnt",       32'(oam_cnt), 256);
    check("wext_first_rd",  32'(first_rd), 'h0200);
    check("wext_ready_low", 32'(ready_low), 516);
    check("wext_parity",    32'(par_bad), 0);
    cycle(); cycle();

    // Retrigger with 0x07 during HALT must be ignored.
    clear_stats(8'h02);
    trigger(8'h02, 1'b1);
    cycle();
    cpu_addr = 16'h4014; cpu_write = 1'b1; cpu_d_out = 8'h07;
    cycle();
    cpu_read();
    wait_done("retrig");
    check("retrig_cnt",       32'(oam_cnt), 256);
    check("retrig_src",       32'(src_bad), 0);
    check("retrig_first_rd",  32'(first_rd), 'h0200);
    check("retrig_last_rd",   32'(last_rd), 'h02FF);
    check("retrig_ready_low", 32'(ready_low), 516);
    cycle(); cycle();

    // Page 0xFF: no carry out of the low address byte.
    clear_stats(8'hFF);
    trigger(8'hFF, 1'b1);
    cycle();
    cpu_read();
    wait_done("pgff");
    check("pgff_cnt",       32'(oam_cnt), 256);
    check("pgff_first_rd",  32'(first_rd), 'hFF00);
    check("pgff_last_rd",   32'(last_rd), 'hFFFF);
    check("pgff_last_data", 32'(last_data), 'h58);
    check("pgff_data",      32'(data_bad), 0);
    check("pgff_idle",      32'(dma_active), 0);
    cycle(); cycle();

    // Async reset after the 100th OAM write.
    clear_stats(8'h02);
    trigger(8'h02, 1'b1);
    cycle();
    cpu_read();
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        #1;
        if (oam_cnt == 100) begin
          hit = 1'b1;
          break;
        end
      end
      check("arst_reach100", 32'(hit), 1);
    end
    cycle();
    reset = 1'b0;
    cpu_addr = 16'h5555; cpu_write = 1'b1; cpu_d_out = 8'h3C;
    #1;
    check("arst_ready",  32'(cpu_ready), 1);
    check("arst_active", 32'(dma_active), 0);
    check("arst_addr",   32'(bus_addr), 'h5555);
    check("arst_write",  32'(bus_write), 1);
    check("arst_data",   32'(bus_d_out), 'h3C);
    cycle(); cycle();
    cpu_read();
    reset = 1'b1;
    for (int i = 0; i < 600; i++) cycle();
    check("arst_no_more_writes", 32'(oam_cnt), 100);
    check("arst_ready_after",    32'(cpu_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
